mem_wb_stage_reg: RTL and testbench
===================================

// Module: mem_wb_stage_reg
// PURPOSE
//  Parametrised MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer,
//  synchronous flush and a stall-cycle counter. Sits between data-memory access and register-file
//  writeback. Replaces the fixed-width, always-advancing MEM/WB latch, so back-pressure from WB
//  (e.g. a multi-cycle write port) stalls MEM without losing an instruction.
// PARAMETERS
//  DATA_W          32  width of ALU result, memory read data and writeback data
//  ADDR_W           5  destination register address width
//  WB_W             2  WB control width; bit0 = RegWrite, bit1 = MemtoReg
//  CNT_W           16  stall counter width (saturating)
//  ZERO_REG_SQUASH  1  1: clear RegWrite at capture when rd_addr == 0
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst           in   1       synchronous reset, active-high
//  flush         in   1       synchronous kill of all held and incoming entries
//  in_valid      in   1       MEM stage presents an entry
//  in_ready      out  1       stage can accept; registered, = !skid_valid
//  alu_result    in   DATA_W  ALU result from EX/MEM
//  mem_rdata     in   DATA_W  data-memory read data
//  rd_addr       in   ADDR_W  destination register
//  wb_ctrl       in   WB_W    WB control bits
//  out_valid     out  1       WB entry valid
//  out_ready     in   1       WB consumes entry this cycle
//  out_alu       out  DATA_W  held ALU result
//  out_mem       out  DATA_W  held memory read data
//  out_wb_data   out  DATA_W  out_wb[1] ? out_mem : out_alu (combinational)
//  out_rd_addr   out  ADDR_W  held destination register
//  out_wb        out  WB_W    held WB control, forced 0 when out_valid = 0 (combinational gate)
//  stall_cnt     out  CNT_W   cycles with out_valid && !out_ready
// BEHAVIOUR
//  Reset (rst=1 at edge): out_valid=0, skid_valid=0, in_ready=1, stall_cnt=0, all data regs 0.
//  Priority: rst > flush > normal operation.
//  accept = in_valid && in_ready;  fire = out_valid && out_ready.
//  Latency: accepted entry appears on outputs the next cycle when main stage is empty or firing.
//  Main empty (out_valid=0): accept -> main; out_valid=1 next cycle.
//  Main full, fire, skid empty: accept -> main; else out_valid=0 next cycle.
//  Main full, fire, skid full: skid -> main, skid_valid=0; in_ready=0 that cycle so no accept.
//  Main full, no fire, skid empty: accept -> skid; skid_valid=1; in_ready=0 next cycle.
//  Main full, no fire, skid full: hold everything; in_ready stays 0.
//  Order preserved: entries leave in acceptance order; none duplicated or dropped.
//  Capture: if ZERO_REG_SQUASH and rd_addr==0, stored wb_ctrl[0]=0; other bits kept.
//  flush=1: next cycle out_valid=0, skid_valid=0, in_ready=1; input in same cycle discarded;
//   data regs may hold stale values (masked by out_wb gate). stall_cnt unaffected.
//  stall_cnt: +1 each cycle out_valid && !out_ready; saturates at 2^CNT_W-1; cleared only by rst.
//  Reset mid-stall: all entries dropped, counter cleared, in_ready=1 next cycle.
//  Data regs only load on capture/move; no enable toggling when idle.
// TESTING
//  1 Stream: out_ready=1, 4 entries alu=0x10..0x13 back-to-back -> each on out_alu 1 cycle later,
//    out_valid continuous, in_ready stays 1, stall_cnt=0.
//  2 Back-pressure: out_ready=0 after entry A, send B, C -> B in skid, in_ready=0, C held by source;
//    out_ready=1 -> A, B, C leave in order one per cycle; stall_cnt equals stalled cycles.
//  3 Flush with both full: A main, B skid, flush=1 with C presented -> next cycle out_valid=0,
//    out_wb=0, in_ready=1; C never appears.
//  4 Zero reg: rd_addr=0, wb_ctrl=2'b11 -> out_wb=2'b10; rd_addr=5, wb_ctrl=2'b11 -> out_wb=2'b11.
//  5 Writeback mux: wb_ctrl=2'b11, alu=0xAAAA, mem=0x5555 -> out_wb_data=0x5555; bit1=0 -> 0xAAAA.
//  6 Saturation/reset: CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt=15; rst mid-stall ->
//    out_valid=0, stall_cnt=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/mem_wb_stage_reg_if.sv
// MEM->WB channel: MEM-side valid/ready with entry payload, and WB-side valid/ready
// with the held entry plus the selected writeback data.
interface mem_wb_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int WB_W   = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] rd_addr;
    logic [WB_W-1:0]   wb_ctrl;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_alu;
    logic [DATA_W-1:0] out_mem;
    logic [DATA_W-1:0] out_wb_data;
    logic [ADDR_W-1:0] out_rd_addr;
    logic [WB_W-1:0]   out_wb;

    // Surrounding pipeline: drives MEM entries and WB ready, observes the stage outputs.
    modport master (
        output in_valid, alu_result, mem_rdata, rd_addr, wb_ctrl, out_ready,
        input  in_ready, out_valid, out_alu, out_mem, out_wb_data, out_rd_addr, out_wb
    );

    modport slave (
        input  in_valid, alu_result, mem_rdata, rd_addr, wb_ctrl, out_ready,
        output in_ready, out_valid, out_alu, out_mem, out_wb_data, out_rd_addr, out_wb
    );
endinterface

// File: rtl/mem_wb_stage_reg.sv
// MEM->WB pipeline register with valid/ready handshake, one-entry skid buffer behind the
// main entry, synchronous flush and a saturating count of cycles stalled by WB.
module mem_wb_stage_reg #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 5,
    parameter int WB_W            = 2,
    parameter int CNT_W           = 16,
    parameter bit ZERO_REG_SQUASH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    mem_wb_stage_reg_if.slave io_pipe,
    output logic [CNT_W-1:0] o_stall_cnt
);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_alu;
    logic [DATA_W-1:0] r_out_mem;
    logic [ADDR_W-1:0] r_out_rd;
    logic [WB_W-1:0]   r_out_wb;

    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_alu;
    logic [DATA_W-1:0] r_skid_mem;
    logic [ADDR_W-1:0] r_skid_rd;
    logic [WB_W-1:0]   r_skid_wb;

    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_fire;
    logic              w_main_free;
    logic              w_main_from_skid;
    logic              w_main_from_in;
    logic              w_load_skid;
    logic [WB_W-1:0]   w_cap_wb;
    logic [WB_W-1:0]   w_out_wb;

    // The skid entry can only be filled while main is stalled, so it doubles as back-pressure.
    assign w_in_ready  = ~r_skid_valid;
    assign w_accept    = io_pipe.in_valid & w_in_ready;
    assign w_fire      = r_out_valid & io_pipe.out_ready;
    assign w_main_free = ~r_out_valid | w_fire;

    always_comb begin
        w_cap_wb = io_pipe.wb_ctrl;
        if (ZERO_REG_SQUASH && (io_pipe.rd_addr == '0)) begin
            w_cap_wb[0] = 1'b0;
        end
    end

    always_comb begin
        w_main_from_skid = 1'b0;
        w_main_from_in   = 1'b0;
        w_load_skid      = 1'b0;
        if (!i_flush) begin
            if (w_main_free) begin
                w_main_from_skid = r_skid_valid;
                w_main_from_in   = ~r_skid_valid & w_accept;
            end else begin
                w_load_skid = w_accept;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (i_flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_main_free) begin
                r_out_valid <= r_skid_valid | w_accept;
            end
            if (w_main_from_skid) begin
                r_skid_valid <= 1'b0;
            end else if (w_load_skid) begin
                r_skid_valid <= 1'b1;
            end
        end
    end

    // Payload registers only move on a capture or skid->main transfer; flush leaves them stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_alu  <= '0;
            r_out_mem  <= '0;
            r_out_rd   <= '0;
            r_out_wb   <= '0;
            r_skid_alu <= '0;
            r_skid_mem <= '0;
            r_skid_rd  <= '0;
            r_skid_wb  <= '0;
        end else begin
            if (w_main_from_skid) begin
                r_out_alu <= r_skid_alu;
                r_out_mem <= r_skid_mem;
                r_out_rd  <= r_skid_rd;
                r_out_wb  <= r_skid_wb;
            end else if (w_main_from_in) begin
                r_out_alu <= io_pipe.alu_result;
                r_out_mem <= io_pipe.mem_rdata;
                r_out_rd  <= io_pipe.rd_addr;
                r_out_wb  <= w_cap_wb;
            end
            if (w_load_skid) begin
                r_skid_alu <= io_pipe.alu_result;
                r_skid_mem <= io_pipe.mem_rdata;
                r_skid_rd  <= io_pipe.rd_addr;
                r_skid_wb  <= w_cap_wb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !io_pipe.out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign w_out_wb = r_out_valid ? r_out_wb : '0;

    assign io_pipe.in_ready    = w_in_ready;
    assign io_pipe.out_valid   = r_out_valid;
    assign io_pipe.out_alu     = r_out_alu;
    assign io_pipe.out_mem     = r_out_mem;
    assign io_pipe.out_rd_addr = r_out_rd;
    assign io_pipe.out_wb      = w_out_wb;
    assign io_pipe.out_wb_data = w_out_wb[1] ? r_out_mem : r_out_alu;
    assign o_stall_cnt         = r_stall_cnt;

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Directed bench for mem_wb_stage_reg: inputs change #1 after the rising edge and outputs
// are checked #1 after the following edge, against hand-computed values.
module tb_mem_wb_stage_reg;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [CNT_W-1:0] stallCnt;

    int assertCount = 0;
    int failCount   = 0;

    mem_wb_stage_reg_if #(.DATA_W(32), .ADDR_W(5), .WB_W(2)) pipe ();

    mem_wb_stage_reg #(
        .DATA_W(32), .ADDR_W(5), .WB_W(2), .CNT_W(CNT_W), .ZERO_REG_SQUASH(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (flush),
        .io_pipe     (pipe),
        .o_stall_cnt (stallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then advance to #1 after the next rising edge.
    task automatic applyStimulus(input logic vld, input logic [31:0] alu, input logic [31:0] mem,
                                 input logic [4:0] rd, input logic [1:0] wb,
                                 input logic ordy, input logic fl, input logic rs);
        pipe.in_valid   = vld;
        pipe.alu_result = alu;
        pipe.mem_rdata  = mem;
        pipe.rd_addr    = rd;
        pipe.wb_ctrl    = wb;
        pipe.out_ready  = ordy;
        flush           = fl;
        rst             = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        pipe.in_valid   = 1'b0;
        pipe.alu_result = '0;
        pipe.mem_rdata  = '0;
        pipe.rd_addr    = '0;
        pipe.wb_ctrl    = '0;
        pipe.out_ready  = 1'b0;
        flush           = 1'b0;
        rst             = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1);

        checkOutput("reset out_valid", {31'b0, pipe.out_valid}, 32'd0);
        checkOutput("reset in_ready",  {31'b0, pipe.in_ready},  32'd1);
        checkOutput("reset stall_cnt", {28'b0, stallCnt},       32'd0);
        checkOutput("reset out_alu",   pipe.out_alu,            32'd0);
        checkOutput("reset out_wb",    {30'b0, pipe.out_wb},    32'd0);

        $display("[TB] streaming four entries");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'h10 + k, 32'h0, 5'd1, 2'b01, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("stream%0d out_valid", k), {31'b0, pipe.out_valid}, 32'd1);
            checkOutput($sformatf("stream%0d out_alu", k),   pipe.out_alu,            32'h10 + k);
            checkOutput($sformatf("stream%0d in_ready", k),  {31'b0, pipe.in_ready},  32'd1);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("stream drained", {31'b0, pipe.out_valid}, 32'd0);
        checkOutput("stream stall_cnt", {28'b0, stallCnt}, 32'd0);

        $display("[TB] back-pressure with skid");
        applyStimulus(1'b1, 32'hA, 32'h0, 5'd2, 2'b01, 1'b1, 1'b0, 1'b0);
        checkOutput("bp A loaded", pipe.out_alu, 32'hA);
        applyStimulus(1'b1, 32'hB, 32'h0, 5'd2, 2'b01, 1'b0, 1'b0, 1'b0);
        checkOutput("bp B skid in_ready", {31'b0, pipe.in_ready}, 32'd0);
        checkOutput("bp A held", pipe.out_alu, 32'hA);
        checkOutput("bp stall 1", {28'b0, stallCnt}, 32'd1);
        applyStimulus(1'b1, 32'hC, 32'h0, 5'd2, 2'b01, 1'b0, 1'b0, 1'b0);
        checkOutput("bp C held off", {31'b0, pipe.in_ready}, 32'd0);
        checkOutput("bp A still held", pipe.out_alu, 32'hA);
        checkOutput("bp stall 2", {28'b0, stallCnt}, 32'd2);
        applyStimulus(1'b1, 32'hC, 32'h0, 5'd2, 2'b01, 1'b1, 1'b0, 1'b0);
        checkOutput("bp B out", pipe.out_alu, 32'hB);
        checkOutput("bp B valid", {31'b0, pipe.out_valid}, 32'd1);
        checkOutput("bp ready again", {31'b0, pipe.in_ready}, 32'd1);
        applyStimulus(1'b1, 32'hC, 32'h0, 5'd2, 2'b01, 1'b1, 1'b0, 1'b0);
        checkOutput("bp C out", pipe.out_alu, 32'hC);
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("bp drained", {31'b0, pipe.out_valid}, 32'd0);
        checkOutput("bp stall total", {28'b0, stallCnt}, 32'd2);

        $display("[TB] flush with main and skid full");
        applyStimulus(1'b1, 32'h1A, 32'h0, 5'd3, 2'b01, 1'b0, 1'b0, 1'b0);
        checkOutput("fl A wb", {30'b0, pipe.out_wb}, 32'd1);
        applyStimulus(1'b1, 32'h1B, 32'h0, 5'd3, 2'b01, 1'b0, 1'b0, 1'b0);
        checkOutput("fl skid full", {31'b0, pipe.in_ready}, 32'd0);
        applyStimulus(1'b1, 32'h1C, 32'h0, 5'd3, 2'b01, 1'b0, 1'b1, 1'b0);
        checkOutput("fl out_valid", {31'b0, pipe.out_valid}, 32'd0);
        checkOutput("fl out_wb gated", {30'b0, pipe.out_wb}, 32'd0);
        checkOutput("fl in_ready", {31'b0, pipe.in_ready}, 32'd1);
        checkOutput("fl stall kept", {28'b0, stallCnt}, 32'd4);
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("fl C dropped", {31'b0, pipe.out_valid}, 32'd0);

        $display("[TB] zero-register squash");
        applyStimulus(1'b1, 32'h1, 32'h0, 5'd0, 2'b11, 1'b1, 1'b0, 1'b0);
        checkOutput("zr rd0 wb", {30'b0, pipe.out_wb}, 32'd2);
        applyStimulus(1'b1, 32'h2, 32'h0, 5'd5, 2'b11, 1'b1, 1'b0, 1'b0);
        checkOutput("zr rd5 wb", {30'b0, pipe.out_wb}, 32'd3);
        checkOutput("zr rd5 addr", {27'b0, pipe.out_rd_addr}, 32'd5);

        $display("[TB] writeback mux");
        applyStimulus(1'b1, 32'hAAAA, 32'h5555, 5'd7, 2'b11, 1'b1, 1'b0, 1'b0);
        checkOutput("mux mem sel", pipe.out_wb_data, 32'h5555);
        checkOutput("mux out_mem", pipe.out_mem, 32'h5555);
        applyStimulus(1'b1, 32'hAAAA, 32'h5555, 5'd7, 2'b01, 1'b1, 1'b0, 1'b0);
        checkOutput("mux alu sel", pipe.out_wb_data, 32'hAAAA);
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0);

        $display("[TB] stall saturation and reset mid-stall");
        applyStimulus(1'b1, 32'h77, 32'h0, 5'd4, 2'b01, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h78, 32'h0, 5'd4, 2'b01, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 10; k++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("sat stall 14", {28'b0, stallCnt}, 32'd14);
        for (int k = 10; k < 20; k++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("sat stall 15", {28'b0, stallCnt}, 32'd15);
        checkOutput("sat held valid", {31'b0, pipe.out_valid}, 32'd1);
        checkOutput("sat held alu", pipe.out_alu, 32'h77);
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("rst out_valid", {31'b0, pipe.out_valid}, 32'd0);
        checkOutput("rst stall_cnt", {28'b0, stallCnt}, 32'd0);
        checkOutput("rst in_ready", {31'b0, pipe.in_ready}, 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("rst skid dropped", {31'b0, pipe.out_valid}, 32'd0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
